add_pipe: RTL
=============

# add_pipe

Pipelined two-operand adder/subtractor on the DTI valid/ready interface. Output width is configurable, with optional saturation, and there are LATENCY register stages. The pipeline is bubble-collapsing, so it keeps full throughput under backpressure. It drops in wherever a combinational adder on the datapath limits timing or needs subtract/saturate behaviour.

## Interface
- DIN0, 0, width of din0.data (≥1)
- DIN1, 0, width of din1.data (≥1)
- DIN0_SIGNED, 0, din0 is two's complement
- DIN1_SIGNED, 0, din1 is two's complement
- SUB, 0, 0: dout = din0 + din1; 1: dout = din0 − din1
- DOUT, 0, output width; 0 selects full precision TFULL
- SAT, 0, when DOUT < TFULL: 1 clamps to output range, 0 keeps low DOUT bits (wrap)
- LATENCY, 1, number of register stages (≥1)
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- din0  dti_s_if.consumer  DIN0  operand 0 (data, valid, ready)
- din1  dti_s_if.consumer  DIN1  operand 1
- dout  dti_s_if.producer  DOUT or TFULL  result

## Operation
- OUT_SIGNED = DIN0_SIGNED | DIN1_SIGNED | SUB.
- Operand extension: each operand is sign-extended if signed, otherwise zero-extended.
  - An unsigned operand gains one extra bit when OUT_SIGNED = 1.
- TFULL = max(extended DIN0, extended DIN1) + 1. The full-precision result never overflows.
- Join: the input transfer fires when din0.valid & din1.valid & s0_accept.
  - din0.ready and din1.ready are both driven equal to this transfer term.
  - ready is never asserted without both valids.
  - Neither operand is consumed alone.
- The result is computed at TFULL width from the input registers' source data.
- Narrowing (DOUT < TFULL) is applied before the stage-0 register:
  - SAT=1, signed output: clamp to [−2^(DOUT−1), 2^(DOUT−1)−1].
  - SAT=1, unsigned output: clamp to [0, 2^DOUT−1].
  - SAT=0: truncate to the low DOUT bits.
- DOUT > TFULL: the result is sign- or zero-extended per OUT_SIGNED.
- Pipeline: stage k holds v[k] and d[k]; the last stage drives dout.valid and dout.data.
  - stall[last] = v[last] & ~dout.ready.
  - stall[k] = v[k] & stall[k+1].
  - Stage k loads from stage k−1 (or from the input join for k=0) whenever ~stall[k].
  - s0_accept = ~stall[0].
- Bubble-collapsing: an empty stage always accepts, even while later stages are stalled.
- The pipeline holds at most LATENCY items. Order is preserved; no item is dropped or duplicated.
- The d[k] registers load only when the incoming valid is 1. Data of invalid stages is don't-care but stable.

## Timing
- Reset: all v[k] = 0 and all d[k] = 0.
  - Result: dout.valid = 0, dout.data = 0, din0.ready = din1.ready = 0 during and in the cycle after rst.
- rst asserted mid-operation discards every in-flight item on the next edge; no partial output follows.
- Latency: an input transfer in cycle t gives dout.valid = 1 in cycle t+LATENCY, provided no stall occurred.
- Throughput: 1 result/cycle while dout.ready = 1.
- dout.valid and dout.data are register outputs and hold stable while dout.valid & ~dout.ready.
- din*.ready is combinational from din*.valid and dout.ready. There is no combinational path from din*.data to dout.
- Full: with all LATENCY stages valid and dout.ready = 0, input ready = 0.
  - If dout.ready goes high in that cycle, the input transfer fires in the same cycle (simultaneous pop/push).
- One operand valid, other not: no transfer, and the waiting operand is not acknowledged.

## Structure
- Shared package: a width helper function (TFULL, OUT_SIGNED from parameters) and sat/trunc constant helpers. These are reusable by future mul/sub blocks.
- Sub-module `dti_pipe_stage`: one valid/data register with stall logic, chained LATENCY times via generate. It is reusable for any pipelined DTI datapath.
- Arithmetic, extension and narrowing stay combinational in add_pipe ahead of stage 0.

## Test plan
- DIN0=DIN1=8 unsigned, SUB=0, LATENCY=1: inputs 255, 255 → dout.data = 510 (9 bits), one cycle after transfer.
- DIN0=DIN1=8 unsigned, SUB=1: inputs 3, 5 → OUT_SIGNED, TFULL=10, dout = 10'h3FE (−2).
- DIN0=DIN1=8 signed, DOUT=8, SAT=1:
  - 100+100 → 127.
  - −100+−100 → −128.
  - With SAT=0, 100+100 → −56.
- LATENCY=3, stream 0..9 as din0, din1 = 1:
  - Hold dout.ready low cycles 2–8.
  - Exactly 3 items are accepted, then ready drops.
  - After release, outputs are 1..10 in order at 1/cycle.
- din0.valid high with din1.valid low for 5 cycles → no ready and no output. din1.valid rises → single transfer.
- rst pulsed for one cycle while 2 items are in flight (LATENCY=3) → dout.valid = 0 next cycle, and no stale results appear afterwards.

Source files
------------

// File: rtl/add_pipe_pkg.sv
// Shared width and saturation helpers for the DTI arithmetic pipelines
// (add_pipe today, mul/sub blocks later).
package add_pipe_pkg;

  localparam int SAT_W = 64;

  function automatic bit out_signed(input bit s0, input bit s1, input bit sub);
    return s0 | s1 | sub;
  endfunction

  // An unsigned operand needs one more bit to stay non-negative in a signed result.
  function automatic int ext_width(input int w, input bit sgn, input bit os);
    return (os && !sgn) ? w + 1 : w;
  endfunction

  function automatic int tfull(input int w0, input int w1,
                               input bit s0, input bit s1, input bit sub);
    int e0;
    int e1;
    bit os;
    os = out_signed(s0, s1, sub);
    e0 = ext_width(w0, s0, os);
    e1 = ext_width(w1, s1, os);
    return ((e0 > e1) ? e0 : e1) + 1;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_hi(input int w, input bit sgn);
    logic signed [SAT_W-1:0] one;
    one = SAT_W'(1);
    return sgn ? (one <<< (w - 1)) - one : (one <<< w) - one;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_lo(input int w, input bit sgn);
    logic signed [SAT_W-1:0] one;
    one = SAT_W'(1);
    return sgn ? -(one <<< (w - 1)) : '0;
  endfunction

endpackage

// File: rtl/dti_s_if.sv
// Streaming valid/ready bundle with a single data field.
interface dti_s_if #(
  parameter int W = 8
) ();
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport producer (output data, output valid, input ready);
  modport consumer (input data, input valid, output ready);
endinterface

// File: rtl/dti_pipe_stage.sv
// One valid/data register of a bubble-collapsing DTI pipeline.
module dti_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_vld,
  input  logic [W-1:0] up_dat,
  input  logic         dn_stall,
  output logic         vld,
  output logic [W-1:0] dat,
  output logic         stall
);

  // An empty stage never stalls, so bubbles are squeezed out under backpressure.
  assign stall = vld & dn_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (!stall) begin
      vld <= up_vld;
      if (up_vld) dat <= up_dat;
    end
  end

endmodule

// File: rtl/add_pipe.sv
// Pipelined adder/subtractor with optional saturation on DTI valid/ready.
module add_pipe
  import add_pipe_pkg::*;
#(
  parameter int DIN0        = 8,
  parameter int DIN1        = 8,
  parameter bit DIN0_SIGNED = 1'b0,
  parameter bit DIN1_SIGNED = 1'b0,
  parameter bit SUB         = 1'b0,
  parameter int DOUT        = 0,
  parameter bit SAT         = 1'b0,
  parameter int LATENCY     = 1
) (
  input logic       clk,
  input logic       rst,
  dti_s_if.consumer din0,
  dti_s_if.consumer din1,
  dti_s_if.producer dout
);

  localparam bit OS = out_signed(DIN0_SIGNED, DIN1_SIGNED, SUB);
  localparam int TF = tfull(DIN0, DIN1, DIN0_SIGNED, DIN1_SIGNED, SUB);
  localparam int OW = (DOUT == 0) ? TF : DOUT;
  // One guard bit above both widths keeps the arithmetic exact for every mode.
  localparam int CW = ((OW > TF) ? OW : TF) + 1;
  localparam logic signed [CW-1:0] HI = CW'(sat_hi(OW, OS));
  localparam logic signed [CW-1:0] LO = CW'(sat_lo(OW, OS));

  function automatic logic [OW-1:0] narrow(input logic signed [CW-1:0] s);
    if (SAT && (OW < TF)) begin
      if (s > HI) return HI[OW-1:0];
      if (s < LO) return LO[OW-1:0];
    end
    return s[OW-1:0];
  endfunction

  logic signed [CW-1:0] a_x;
  logic signed [CW-1:0] b_x;
  logic signed [CW-1:0] sum;
  logic [OW-1:0]        res;
  logic                 rst_d1;
  logic                 xfer;

  always_comb begin
    a_x = DIN0_SIGNED ? {{(CW-DIN0){din0.data[DIN0-1]}}, din0.data}
                      : {{(CW-DIN0){1'b0}}, din0.data};
    b_x = DIN1_SIGNED ? {{(CW-DIN1){din1.data[DIN1-1]}}, din1.data}
                      : {{(CW-DIN1){1'b0}}, din1.data};
    sum = SUB ? a_x - b_x : a_x + b_x;
  end

  assign res = narrow(sum);

  always_ff @(posedge clk) rst_d1 <= rst;

  // Both operands are taken together or not at all; ready stays low through reset recovery.
  assign xfer       = din0.valid & din1.valid & ~g_stage[0].stall & ~rst & ~rst_d1;
  assign din0.ready = xfer;
  assign din1.ready = xfer;

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    logic          up_vld;
    logic [OW-1:0] up_dat;
    logic          dn_stall;
    logic          vld;
    logic [OW-1:0] dat;
    logic          stall;

    if (k == 0) begin : g_head
      assign up_vld = xfer;
      assign up_dat = res;
    end else begin : g_body
      assign up_vld = g_stage[k-1].vld;
      assign up_dat = g_stage[k-1].dat;
    end

    if (k == LATENCY - 1) begin : g_tail
      assign dn_stall = ~dout.ready;
    end else begin : g_mid
      assign dn_stall = g_stage[k+1].stall;
    end

    dti_pipe_stage #(.W(OW)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_vld   (up_vld),
      .up_dat   (up_dat),
      .dn_stall (dn_stall),
      .vld      (vld),
      .dat      (dat),
      .stall    (stall)
    );
  end

  assign dout.valid = g_stage[LATENCY-1].vld;
  assign dout.data  = g_stage[LATENCY-1].dat;

endmodule
